sample_fifo: RTL and testbench



---
 rtl/sample_fifo.sv | 113 +++++++++++
 tb/tb_sample_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock sample buffer between an audio producer and a
// frame serializer. Request/valid read port, almost-full flow control,
// and a tap-delay shift register used to sequence the serializer pipeline.
module sample_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int MAX_ITEMS  = (1 << ADDR_WIDTH) - 8,
   parameter int TAP_DEPTH  = 9
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_w,
   input  logic                  we,
   output logic                  almost_full,
   input  logic                  req,
   output logic [DATA_WIDTH-1:0] data_r,
   output logic                  valid,
   output logic                  empty,
   input  logic                  tap_in,
   output logic [TAP_DEPTH-1:0]  taps
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(MAX_ITEMS);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
   logic                  valid_q,  valid_d;
   logic [TAP_DEPTH-1:0]  taps_q,   taps_d;

   logic do_write;
   logic do_read;

   // Flags decode straight from the registered count, so they move on the
   // same edge as the count itself.
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= CNT_AF);

   // Full and empty are judged on pre-edge state: a write into an empty FIFO
   // cannot be read in the same cycle, and a read at full still pops while
   // the concurrent write is dropped.
   assign do_write = we  && (count_q != CNT_FULL);
   assign do_read  = req && !empty;

   // Next-state for pointers, occupancy, read port and delay line.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      data_r_d = data_r_q;
      valid_d  = do_read;
      taps_d   = {taps_q[TAP_DEPTH-2:0], tap_in};

      if (do_write) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_read) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         data_r_d = mem_q[rd_ptr_q];
      end

      case ({do_write, do_read})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control and output registers; reset discards all stored words.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_r_q <= '0;
         valid_q  <= 1'b0;
         taps_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_r_q <= data_r_d;
         valid_q  <= valid_d;
         taps_q   <= taps_d;
      end
   end

   // Sample storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; occupancy gating makes stale
      // contents unreachable and keeps the array mappable to plain RAM.
      if (do_write) begin
         mem_q[wr_ptr_q] <= data_w;
      end
   end

   assign data_r = data_r_q;
   assign valid  = valid_q;
   assign taps   = taps_q;

endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: directed vectors with hand-computed expectations for
// sample_fifo (reset, ordering, almost-full, saturation, same-cycle
// write/read, delay-line taps, mid-operation reset).
module tb_sample_fifo;

   localparam int DW = 32;
   localparam int TD = 9;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] data_w;
   logic          we;
   logic          almost_full;
   logic          req;
   logic [DW-1:0] data_r;
   logic          valid;
   logic          empty;
   logic          tap_in;
   logic [TD-1:0] taps;

   int n_tests = 0;
   int n_fail  = 0;

   sample_fifo dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_w     (data_w),
      .we         (we),
      .almost_full(almost_full),
      .req        (req),
      .data_r     (data_r),
      .valid      (valid),
      .empty      (empty),
      .tap_in     (tap_in),
      .taps       (taps)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      data_w  = '0;
      we      = 1'b0;
      req     = 1'b0;
      tap_in  = 1'b0;
      #1;
      // Reset state
      check("rst_empty", empty, 1);
      check("rst_af",    almost_full, 0);
      check("rst_valid", valid, 0);
      check("rst_data",  data_r, 0);
      check("rst_taps",  taps, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("idle_empty", empty, 1);

      // Three writes then four requests
      we = 1'b1;
      data_w = 32'h1111_0000; tick();
      check("w1_empty", empty, 0);
      data_w = 32'h2222_0001; tick();
      data_w = 32'h3333_0002; tick();
      we = 1'b0;
      req = 1'b1;
      tick();
      check("r1_valid", valid, 1);
      check("r1_data",  data_r, 32'h1111_0000);
      tick();
      check("r2_valid", valid, 1);
      check("r2_data",  data_r, 32'h2222_0001);
      tick();
      check("r3_valid", valid, 1);
      check("r3_data",  data_r, 32'h3333_0002);
      check("r3_empty", empty, 1);
      tick();
      check("r4_valid", valid, 0);
      check("r4_empty", empty, 1);
      check("r4_hold",  data_r, 32'h3333_0002);
      req = 1'b0;
      tick();

      // Almost-full threshold at 8 entries
      we = 1'b1;
      for (int k = 0; k < 8; k++) begin
         data_w = 32'h100 + k;
         tick();
         if (k == 6) check("af_at7", almost_full, 0);
      end
      we = 1'b0;
      check("af_at8", almost_full, 1);
      req = 1'b1;
      tick();
      req = 1'b0;
      check("af_fall",   almost_full, 0);
      check("af_rvalid", valid, 1);
      check("af_rdata",  data_r, 32'h100);
      tick();
      check("af_vdrop", valid, 0);
      req = 1'b1;
      for (int k = 1; k < 8; k++) begin
         tick();
         check($sformatf("af_drain%0d", k), data_r, 32'h100 + k);
      end
      req = 1'b0;
      check("af_empty", empty, 1);
      tick();

      // Saturation: write 0..19, last four dropped; read+write at full pops only
      we = 1'b1;
      for (int k = 0; k < 20; k++) begin
         data_w = k;
         tick();
      end
      check("sat_af",    almost_full, 1);
      check("sat_empty", empty, 0);
      data_w = 32'hDEAD_BEEF;
      req = 1'b1;
      tick();
      we = 1'b0;
      check("full_rw_valid", valid, 1);
      check("full_rw_data",  data_r, 0);
      for (int k = 1; k < 16; k++) begin
         tick();
         check($sformatf("sat_rd%0d", k), data_r, k);
      end
      check("sat_empty_end", empty, 1);
      tick();
      check("sat_no_extra", valid, 0);
      req = 1'b0;
      tick();

      // Same-cycle write and read into an empty FIFO
      we = 1'b1;
      req = 1'b1;
      data_w = 32'hABCD_1234;
      tick();
      we = 1'b0;
      check("wr_same_valid", valid, 0);
      check("wr_same_empty", empty, 0);
      tick();
      req = 1'b0;
      check("wr_next_valid", valid, 1);
      check("wr_next_data",  data_r, 32'hABCD_1234);
      tick();
      check("wr_pulse_end", valid, 0);

      // Delay-line pulse walks one stage per cycle
      tap_in = 1'b1;
      tick();
      tap_in = 1'b0;
      for (int k = 0; k < TD; k++) begin
         check($sformatf("tap%0d", k), taps, 9'(1) << k);
         tick();
      end
      check("tap_clear", taps, 0);

      // Reset mid-operation discards stored words
      we = 1'b1;
      data_w = 32'h5555_AAAA; tick();
      data_w = 32'h6666_BBBB; tick();
      we = 1'b0;
      check("mid_pre_empty", empty, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_empty", empty, 1);
      check("mid_rst_data",  data_r, 0);
      tick();
      reset_n = 1'b1;
      req = 1'b1;
      tick();
      req = 1'b0;
      check("mid_post_valid", valid, 0);
      check("mid_post_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
